// File: rtl/btn_pkg.sv
// Shared constants for the push-button front end: timing defaults and the
// electrical sense of the active-low button pins.
package btn_pkg;

    localparam int CLK_HZ = 27000000;

    // 10 ms of stable samples at the board clock.
    localparam int DEFAULT_DEBOUNCE_CYCLES = CLK_HZ / 100;

    localparam logic BTN_PRESSED  = 1'b0;
    localparam logic BTN_RELEASED = 1'b1;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, stable-count debouncer, and
// registered press/release pulses plus an active-low run/pause toggle.
module debounce_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
)
(
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic db_n,
    output logic press,
    output logic release_pulse,
    output logic toggle_n
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             differs;
    logic             accept;

    always_comb begin
        differs = (s2 != db_n);
        accept  = differs && (cnt == CNT_MAX);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= BTN_RELEASED;
            s2 <= BTN_RELEASED;
        end else begin
            s1 <= btn_n;
            s2 <= s1;
        end
    end

    // Any sample matching the accepted level restarts the stable count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!differs || accept) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Pulses come from the accept condition so they align with the db_n edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_n          <= BTN_RELEASED;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            toggle_n      <= 1'b1;
        end else begin
            press         <= accept && (s2 == BTN_PRESSED);
            release_pulse <= accept && (s2 == BTN_RELEASED);
            if (accept) begin
                db_n <= s2;
                if (s2 == BTN_PRESSED) begin
                    toggle_n <= ~toggle_n;
                end
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the board's active-low push buttons for the LED counter; the
// release pulse port is named release_pulse because release is a reserved word.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_n,
    output logic [N_BTN-1:0] db_n,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] toggle_n
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk          (clk),
            .reset        (reset),
            .btn_n        (btn_n[i]),
            .db_n         (db_n[i]),
            .press        (press[i]),
            .release_pulse(release_pulse[i]),
            .toggle_n     (toggle_n[i])
        );
    end

endmodule
